// File: rtl/uart_pkg.sv
// Shared state encodings for the UART receiver and transmitter FSMs.
package uart_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: latches a byte on i_start and shifts it out LSB first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_start,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_line, w_line_nxt;
  logic             r_busy, w_busy_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TxIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_line  <= w_line_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // The line is registered, so each next-bit value is chosen one edge before it appears.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_line_nxt  = r_line;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      TxIdle: begin
        w_cnt_nxt = '0;
        if (i_start) begin
          w_shift_nxt = i_data;
          w_line_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = TxStart;
        end
      end
      TxStart: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_line_nxt  = r_shift[0];
          w_state_nxt = TxData;
        end
      end
      TxData: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_line_nxt  = 1'b1;
            w_state_nxt = TxStop;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_line_nxt  = r_shift[1];
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
      end
      TxStop: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = TxIdle;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_line_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = TxIdle;
      end
    endcase
  end

  assign o_tx   = r_line;
  assign o_busy = r_busy;

endmodule

// File: rtl/uart.sv
// 8N1 UART: inline mid-bit-sampling receiver plus an instantiated transmitter.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  rx_state_e        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_idx, w_rx_idx_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic [7:0]       r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_state  <= RxIdle;
      r_rx_cnt    <= '0;
      r_rx_idx    <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_idx    <= w_rx_idx_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Half a bit into START puts every later sample near the middle of its bit.
  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_cnt_nxt    = r_rx_cnt + CNT_W'(1);
    w_rx_idx_nxt    = r_rx_idx;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        w_rx_cnt_nxt = '0;
        if (!r_rx_sync) begin
          w_rx_idx_nxt   = '0;
          w_rx_state_nxt = RxStart;
        end
      end
      RxStart: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_idx_nxt   = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) w_rx_state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_rx_data_nxt  = r_rx_shift;
            w_rx_valid_nxt = 1'b1;
            w_rx_state_nxt = RxIdle;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_rx_state_nxt  = RxWaitHigh;
          end
        end
      end
      RxWaitHigh: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_sync) w_rx_state_nxt = RxIdle;
      end
      default: begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = RxIdle;
      end
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk  (clk_i),
    .i_rst_n(rst_i),
    .i_data (tx_data),
    .i_start(tx_start),
    .o_tx   (uart_tx),
    .o_busy (tx_busy)
  );

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: frames are queued when driven and checked when the DUT reports them.
module tb_uart;

  localparam int unsigned CLK_HZ = 2000000;
  localparam int unsigned BAUD_R = 100000;
  localparam int unsigned CPB    = CLK_HZ / BAUD_R;
  localparam int unsigned HALF   = CPB / 2;
  localparam int unsigned LAT    = HALF + 9 * CPB + 3;

  logic       clk_i;
  logic       rst_i;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       uart_tx;
  logic       tx_busy;

  uart #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int unsigned start_cyc;
  } rx_exp_t;

  rx_exp_t     rx_q[$];
  logic [7:0]  tx_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_fails   = 0;
  int unsigned cyc       = 0;
  logic [7:0]  last_good = 8'h00;
  logic        tx_mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Receive-side scoreboard: every pulse must match the oldest queued frame.
  initial begin : rx_mon
    logic        valid_prev;
    logic        ferr_prev;
    rx_exp_t     e;
    int unsigned lat;
    valid_prev = 1'b0;
    ferr_prev  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        valid_prev = 1'b0;
        ferr_prev  = 1'b0;
      end else begin
        if (valid_prev) check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
        if (ferr_prev) check("frame_err_one_cycle", 32'(frame_err), 32'd0);
        if (rx_valid || frame_err) begin
          if (rx_q.size() == 0) begin
            check("rx_pulse_expected", 32'(rx_q.size()), 32'd1);
          end else begin
            e   = rx_q.pop_front();
            lat = cyc - e.start_cyc;
            check("rx_kind_frame_err", 32'(frame_err), 32'(e.err));
            check("rx_data", 32'(rx_data), 32'(e.data));
            if (lat + 1 < LAT || lat > LAT + 1) check("rx_latency", lat, LAT);
            else check("rx_latency", 32'd1, 32'd1 & 32'(rx_valid | frame_err));
          end
        end
        valid_prev = rx_valid;
        ferr_prev  = frame_err;
      end
    end
  end

  // Transmit-side scoreboard: decode uart_tx at mid-bit and compare with queued bytes.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (tx_mon_en && rst_i && prev && !uart_tx) begin
        repeat (HALF - 1) @(negedge clk_i);
        check("tx_start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_i);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk_i);
        check("tx_stop_bit", 32'(uart_tx), 32'd1);
        if (tx_q.size() == 0) check("tx_frame_expected", 32'(tx_q.size()), 32'd1);
        else check("tx_data", 32'(b), 32'(tx_q.pop_front()));
      end
      prev = uart_tx;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic expect_it);
    logic [7:0] held;
    rx_exp_t    e;
    held = last_good;
    @(posedge clk_i);
    #1;
    uart_rx = 1'b0;
    if (expect_it) begin
      e.data      = stop_ok ? d : last_good;
      e.err       = !stop_ok;
      e.start_cyc = cyc;
      rx_q.push_back(e);
      if (stop_ok) last_good = d;
    end
    repeat (CPB) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(posedge clk_i);
      #1;
      if (i == 4 && expect_it) check("rx_data_hold", 32'(rx_data), 32'(held));
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge clk_i);
    #1;
    if (!stop_ok) begin
      repeat (2 * CPB) @(posedge clk_i);
      #1;
    end
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk_i);
  endtask

  // One transmission, with a competing tx_start injected while busy.
  task automatic tx_frame(input logic [7:0] d);
    int unsigned n;
    n = 0;
    @(posedge clk_i);
    #1;
    tx_data  = d;
    tx_start = 1'b1;
    tx_q.push_back(d);
    @(posedge clk_i);
    #1;
    tx_start = 1'b0;
    check("tx_busy_set", 32'(tx_busy), 32'd1);
    while (tx_busy && n < 20 * CPB) begin
      n++;
      if (n == 3 * CPB) begin
        tx_data  = ~d;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(posedge clk_i);
      #1;
    end
    tx_start = 1'b0;
    check("tx_busy_cycles", n, 10 * CPB);
    repeat (2 * CPB) @(posedge clk_i);
    #1;
    check("tx_line_idle", 32'(uart_tx), 32'd1);
    check("tx_busy_clear", 32'(tx_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_rx_data"}, 32'(rx_data), 32'h00);
    check({phase, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({phase, "_frame_err"}, 32'(frame_err), 32'd0);
    check({phase, "_uart_tx"}, 32'(uart_tx), 32'd1);
    check({phase, "_tx_busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_i    = 1'b0;
    uart_rx  = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hFC, 1'b1, 1'b1);

    // Short low glitch must be rejected at the half-bit start check.
    @(posedge clk_i);
    #1;
    uart_rx = 1'b0;
    repeat (HALF - 3) @(posedge clk_i);
    #1;
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk_i);

    send_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);

    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      tx_frame(8'hA3);
    join

    // Reset in the middle of both a receive and a transmit.
    tx_mon_en = 1'b0;
    @(posedge clk_i);
    #1;
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(posedge clk_i);
    #1;
    tx_start = 1'b0;
    fork
      send_frame(8'h69, 1'b1, 1'b0);
      begin
        repeat (4 * CPB) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
      end
    join
    last_good = 8'h00;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    send_frame(8'h96, 1'b1, 1'b1);

    repeat (12 * CPB) @(posedge clk_i);
    tx_mon_en = 1'b1;
    tx_frame(8'h5C);

    repeat (4 * CPB) @(posedge clk_i);
    #1;
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
